muldiv_alu: RTL and testbench
=============================

MULDIV_ALU -- requirements
Module: muldiv_alu

Interface
REQ-001 WIDTH SHALL be a parameter with default 32 and meaning "datapath width"; legal values are even and at least 8.
REQ-002 Clk_In SHALL be an input, 1 bit: the single clock; every register is updated on its rising edge.
REQ-003 Reset_N_In SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-004 Alu_Op_In SHALL be an input, 4 bits: selects the combinational ALU operation.
REQ-005 SrcA_In and SrcB_In SHALL be inputs, WIDTH bits each: the operands for both the ALU and the mul/div unit.
REQ-006 Aluresult_Out SHALL be an output, WIDTH bits: the combinational ALU result.
REQ-007 Md_Op_In SHALL be an input, 3 bits: selects the mul/div operation.
REQ-008 Start_In SHALL be an input, 1 bit: a request, sampled on each rising edge together with Md_Op_In.
REQ-009 Busy_Out SHALL be an output, 1 bit: the mul/div unit is iterating.
REQ-010 Done_Out SHALL be an output, 1 bit: a one-cycle pulse indicating that HI/LO have just been updated.
REQ-011 Hi_Out and Lo_Out SHALL be outputs, WIDTH bits each: the registered HI and LO values.

Function
REQ-012 Aluresult_Out SHALL be a pure function of Alu_Op_In, SrcA_In and SrcB_In, with the following encodings:
- 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR; 5 NOR.
- 6 LUI: SrcB_In[WIDTH/2-1:0] placed in the upper half, lower half zero.
- 7 SLT (signed); 8 SLTU (unsigned).
- 9 SLL, 10 SRL, 11 SRA: shift SrcB_In by SrcA_In[log2(WIDTH)-1:0].
- 12-15: result 0.
- ADD and SUB wrap modulo 2^WIDTH with no overflow flag.
REQ-013 Md_Op_In encodings SHALL be:
- 0 NOP; 1 MULT; 2 MULTU; 3 DIV; 4 DIVU; 5 MTHI; 6 MTLO; 7 NOP.
REQ-014 The state machine SHALL have three states, IDLE, RUN and FIX, with these transitions:
- IDLE to RUN: Start_In=1 with Md_Op_In in 1..4.
- RUN to FIX: after exactly WIDTH iteration cycles.
- FIX to IDLE: always, after one cycle.
REQ-015 Operands SHALL be latched on the accepting edge, so later changes on SrcA_In/SrcB_In have no effect on the operation in progress.
REQ-016 Busy_Out SHALL be 1 exactly while the state is RUN or FIX, which is WIDTH+1 cycles after the accepting edge.
REQ-017 HI/LO SHALL be written on the FIX-to-IDLE edge, and Done_Out SHALL be 1 for exactly the following cycle.
REQ-018 HI/LO SHALL hold their previous values while Busy_Out=1.
REQ-019 The multiply result SHALL be formed as follows:
- {HI,LO} is the full 2*WIDTH-bit product.
- MULT treats both operands as two's complement; MULTU treats them as unsigned.
REQ-020 The divide result SHALL be formed as follows:
- LO is the quotient, truncated toward zero.
- HI is the remainder, taking the sign of the dividend (SrcA_In).
- DIVU is unsigned.
REQ-021 A divisor of zero SHALL give LO = all ones and HI = dividend, with the normal latency.
REQ-022 DIV of the most negative value by -1 SHALL give LO = the most negative value and HI = 0.
REQ-023 MTHI/MTLO with Start_In=1 in IDLE SHALL write SrcA_In into HI/LO on that edge, SHALL NOT assert Busy_Out and SHALL NOT pulse Done_Out.
REQ-024 While Busy_Out=1, any Start_In SHALL be ignored, including MTHI/MTLO requests.
REQ-025 A new operation accepted in the same cycle that Done_Out=1 SHALL be legal.
REQ-026 Start_In with a NOP encoding SHALL have no effect.

Reset
REQ-027 While Reset_N_In=0, the block SHALL asynchronously force the following, including aborting any operation in progress without updating HI/LO:
- State IDLE.
- HI = 0 and LO = 0.
- Busy_Out = 0 and Done_Out = 0.
- Iteration counter and operand registers = 0.
REQ-028 On reset release, the first Start_In SHALL be accepted on the first rising edge after Reset_N_In=1.

Configuration
REQ-029 The macro MULDIV_SIGNED_EN SHALL select signed mul/div support:
- Defined: MULT and DIV behave as specified above.
- Undefined: Md_Op_In 1 and 3 are treated as NOP (no busy, no HI/LO change), and the sign-correction logic is omitted.
- FIX occurs in both builds, so latency is always WIDTH+1.

Verification (WIDTH=32, MULDIV_SIGNED_EN defined)
REQ-030 ALU check: SLT with A=0xFFFFFFFF, B=1 -> Aluresult_Out=1; SLTU with the same operands -> 0; LUI with B=0x00001234 -> 0x12340000.
REQ-031 Unsigned multiply: MULTU 0xFFFFFFFF*2 -> Busy_Out high for 33 cycles, then HI=0x00000001, LO=0xFFFFFFFE and a 1-cycle Done_Out pulse.
REQ-032 Signed multiply and divide:
- MULT -3*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
REQ-033 Divide by zero: DIVU 5/0 -> HI=0x00000005, LO=0xFFFFFFFF after 33 cycles.
REQ-034 Busy and reset: MTLO and MULTU requests issued while Busy_Out=1 -> ignored, and LO holds its value; Reset_N_In pulsed low mid-DIVU -> HI=LO=0, Busy_Out=0 immediately, and no Done_Out pulse.

Source files
------------

// File: rtl/muldiv_alu.sv
// muldiv_alu: combinational ALU plus an iterative multiply/divide unit
// with HI/LO result registers.
//
// Ports
//   Clk_In         clock, rising edge
//   Reset_N_In     asynchronous active-low reset
//   Alu_Op_In      ALU operation select (4 bits)
//   SrcA_In        operand A (ALU shift amount, dividend, MTHI/MTLO data)
//   SrcB_In        operand B (divisor)
//   Aluresult_Out  combinational ALU result
//   Md_Op_In       mul/div operation select (3 bits)
//   Start_In       mul/div request, sampled with Md_Op_In on each edge
//   Busy_Out       unit is iterating (RUN or FIX)
//   Done_Out       one-cycle pulse after HI/LO are written by an iteration
//   Hi_Out/Lo_Out  registered HI/LO
//
// Build option
//   MULDIV_SIGNED_EN  defined: MULT/DIV supported with sign correction.
//                     undefined: MULT/DIV decode as NOP.
//
// Multiply is shift-add and divide is restoring, both on operand
// magnitudes for WIDTH cycles; FIX applies signs and the divide-by-zero
// result before HI/LO are written.

module muldiv_alu #(
    parameter int WIDTH = 32
) (
    input  logic             Clk_In,
    input  logic             Reset_N_In,
    input  logic [3:0]       Alu_Op_In,
    input  logic [WIDTH-1:0] SrcA_In,
    input  logic [WIDTH-1:0] SrcB_In,
    output logic [WIDTH-1:0] Aluresult_Out,
    input  logic [2:0]       Md_Op_In,
    input  logic             Start_In,
    output logic             Busy_Out,
    output logic             Done_Out,
    output logic [WIDTH-1:0] Hi_Out,
    output logic [WIDTH-1:0] Lo_Out
);

    localparam int SW = $clog2(WIDTH);
    localparam int HW = WIDTH / 2;

    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    // ------------------------------------------------------------------
    // Combinational ALU
    // ------------------------------------------------------------------
    logic [SW-1:0] shamt;
    assign shamt = SrcA_In[SW-1:0];

    always_comb begin
        Aluresult_Out = '0;
        case (Alu_Op_In)
            4'd0:  Aluresult_Out = SrcA_In + SrcB_In;
            4'd1:  Aluresult_Out = SrcA_In - SrcB_In;
            4'd2:  Aluresult_Out = SrcA_In & SrcB_In;
            4'd3:  Aluresult_Out = SrcA_In | SrcB_In;
            4'd4:  Aluresult_Out = SrcA_In ^ SrcB_In;
            4'd5:  Aluresult_Out = ~(SrcA_In | SrcB_In);
            4'd6:  Aluresult_Out = {SrcB_In[HW-1:0], {HW{1'b0}}};
            4'd7:  Aluresult_Out = {{(WIDTH-1){1'b0}}, $signed(SrcA_In) < $signed(SrcB_In)};
            4'd8:  Aluresult_Out = {{(WIDTH-1){1'b0}}, SrcA_In < SrcB_In};
            4'd9:  Aluresult_Out = SrcB_In << shamt;
            4'd10: Aluresult_Out = SrcB_In >> shamt;
            4'd11: Aluresult_Out = $signed(SrcB_In) >>> shamt;
            default: Aluresult_Out = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Mul/div request decode
    // ------------------------------------------------------------------
    state_t state_q, state_d;

    logic md_iter, md_div, start_iter;
    logic [WIDTH-1:0] mag_a, mag_b;

`ifdef MULDIV_SIGNED_EN
    logic md_signed, sign_a, sign_b;
    assign md_iter   = (Md_Op_In == MD_MULT) || (Md_Op_In == MD_MULTU) ||
                       (Md_Op_In == MD_DIV)  || (Md_Op_In == MD_DIVU);
    assign md_div    = (Md_Op_In == MD_DIV) || (Md_Op_In == MD_DIVU);
    assign md_signed = (Md_Op_In == MD_MULT) || (Md_Op_In == MD_DIV);
    assign sign_a    = md_signed & SrcA_In[WIDTH-1];
    assign sign_b    = md_signed & SrcB_In[WIDTH-1];
    // The most negative value negates to itself, which is its correct
    // unsigned magnitude.
    assign mag_a     = sign_a ? -SrcA_In : SrcA_In;
    assign mag_b     = sign_b ? -SrcB_In : SrcB_In;
`else
    assign md_iter   = (Md_Op_In == MD_MULTU) || (Md_Op_In == MD_DIVU);
    assign md_div    = (Md_Op_In == MD_DIVU);
    assign mag_a     = SrcA_In;
    assign mag_b     = SrcB_In;
`endif

    assign start_iter = Start_In && (state_q == IDLE) && md_iter;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    logic [SW-1:0] cnt_q;

    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) state_q <= IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_iter) state_d = RUN;
            RUN:  if (cnt_q == SW'(WIDTH-1)) state_d = FIX;
            FIX:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign Busy_Out = (state_q != IDLE);

    // ------------------------------------------------------------------
    // Iteration datapath
    //   acc_q: multiply {partial product high, remaining multiplier}
    //          divide   {partial remainder, dividend bits / quotient bits}
    //   dvs_q: multiplicand (multiply) or divisor (divide) magnitude
    //   dvd_q: raw dividend, kept for the divide-by-zero HI value
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   dvs_q, dvd_q;
    logic               is_div_q;
`ifdef MULDIV_SIGNED_EN
    logic               neg_q;      // negate product / quotient
    logic               rneg_q;     // negate remainder
`endif

    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] mul_next, div_next;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, dvs_q};
        // Bit WIDTH of the trial difference is the borrow: divisor did not fit.
        if (div_trial[WIDTH])
            div_next = {acc_q[2*WIDTH-2:0], 1'b0};
        else
            div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            acc_q    <= '0;
            dvs_q    <= '0;
            dvd_q    <= '0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
`endif
        end else if (start_iter) begin
            is_div_q <= md_div;
            dvd_q    <= SrcA_In;
            dvs_q    <= md_div ? mag_b : mag_a;
            acc_q    <= {{WIDTH{1'b0}}, (md_div ? mag_a : mag_b)};
            cnt_q    <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_q    <= sign_a ^ sign_b;
            rneg_q   <= sign_a & md_div;
`endif
        end else if (state_q == RUN) begin
            acc_q <= is_div_q ? div_next : mul_next;
            cnt_q <= cnt_q + SW'(1);
        end
    end

    // ------------------------------------------------------------------
    // FIX stage result: sign correction and divide-by-zero
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;

    always_comb begin
        prod = acc_q;
        quo  = acc_q[WIDTH-1:0];
        rem  = acc_q[2*WIDTH-1:WIDTH];
`ifdef MULDIV_SIGNED_EN
        if (neg_q) begin
            prod = -acc_q;
            quo  = -acc_q[WIDTH-1:0];
        end
        if (rneg_q) rem = -acc_q[2*WIDTH-1:WIDTH];
`endif
        if (is_div_q) begin
            if (dvs_q == '0) begin
                fix_hi = dvd_q;
                fix_lo = '1;
            end else begin
                fix_hi = rem;
                fix_lo = quo;
            end
        end else begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------
    // HI/LO and Done
    // ------------------------------------------------------------------
    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            Hi_Out   <= '0;
            Lo_Out   <= '0;
            Done_Out <= 1'b0;
        end else begin
            Done_Out <= (state_q == FIX);
            if (state_q == FIX) begin
                Hi_Out <= fix_hi;
                Lo_Out <= fix_lo;
            end else if (state_q == IDLE && Start_In) begin
                // Moves complete on the request edge without going busy.
                if (Md_Op_In == MD_MTHI) Hi_Out <= SrcA_In;
                if (Md_Op_In == MD_MTLO) Lo_Out <= SrcA_In;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_alu.sv
module tb_muldiv_alu;

    logic        Clk_In, Reset_N_In;
    logic [3:0]  Alu_Op_In;
    logic [31:0] SrcA_In, SrcB_In, Aluresult_Out;
    logic [2:0]  Md_Op_In;
    logic        Start_In, Busy_Out, Done_Out;
    logic [31:0] Hi_Out, Lo_Out;

    muldiv_alu #(.WIDTH(32)) dut (
        .Clk_In(Clk_In), .Reset_N_In(Reset_N_In),
        .Alu_Op_In(Alu_Op_In), .SrcA_In(SrcA_In), .SrcB_In(SrcB_In),
        .Aluresult_Out(Aluresult_Out),
        .Md_Op_In(Md_Op_In), .Start_In(Start_In),
        .Busy_Out(Busy_Out), .Done_Out(Done_Out),
        .Hi_Out(Hi_Out), .Lo_Out(Lo_Out)
    );

    initial Clk_In = 1'b0;
    always #5 Clk_In = ~Clk_In;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       nm;
        logic [3:0]  op;
        logic [31:0] a, b, y;
    } alu_vec_t;

    typedef struct {
        logic        iter;
        logic [31:0] hi, lo;
    } md_exp_t;

    alu_vec_t   alu_tab[15];
    md_exp_t    sb_q[$];
    logic [31:0] model_hi = '0, model_lo = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference mul/div result: {iterates, hi, lo}
    function automatic logic [64:0] md_model(input logic [2:0] op, input logic [31:0] a, b, hi, lo);
        logic [63:0] p;
`ifdef MULDIV_SIGNED_EN
        logic signed [63:0] sp;
        logic signed [31:0] sa, sb, q, r;
`endif
        md_model = {1'b0, hi, lo};
        case (op)
`ifdef MULDIV_SIGNED_EN
            3'd1: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                md_model = {1'b1, sp};
            end
            3'd3: begin
                sa = a; sb = b;
                if (b == 32'h0)
                    md_model = {1'b1, a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF)
                    md_model = {1'b1, 32'h0, 32'h80000000};
                else begin
                    q = sa / sb; r = sa % sb;
                    md_model = {1'b1, r, q};
                end
            end
`endif
            3'd2: begin
                p = {32'h0, a} * {32'h0, b};
                md_model = {1'b1, p};
            end
            3'd4: begin
                if (b == 32'h0) md_model = {1'b1, a, 32'hFFFFFFFF};
                else            md_model = {1'b1, a % b, a / b};
            end
            3'd5: md_model = {1'b0, a, lo};
            3'd6: md_model = {1'b0, hi, a};
            default: md_model = {1'b0, hi, lo};
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle Done_Out is seen.
    task automatic wait_done(output bit got, output int busy_cnt);
        got = 0; busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done_Out) begin got = 1; break; end
            if (Busy_Out) busy_cnt++;
            @(posedge Clk_In); #1;
        end
    endtask

    // Issue one request from IDLE, scramble operands afterwards, check result.
    task automatic run_md(input string nm, input logic [2:0] op, input logic [31:0] a, b);
        md_exp_t e;
        logic [64:0] m;
        bit got;
        int bc;
        m = md_model(op, a, b, model_hi, model_lo);
        e.iter = m[64]; e.hi = m[63:32]; e.lo = m[31:0];
        sb_q.push_back(e);
        model_hi = e.hi; model_lo = e.lo;
        Md_Op_In = op; SrcA_In = a; SrcB_In = b; Start_In = 1'b1;
        @(posedge Clk_In); #1;
        Start_In = 1'b0; SrcA_In = $urandom; SrcB_In = $urandom;
        e = sb_q.pop_front();
        if (!e.iter) begin
            chk({nm, "_busy"}, {63'h0, Busy_Out}, 64'h0);
            chk({nm, "_done"}, {63'h0, Done_Out}, 64'h0);
        end else begin
            wait_done(got, bc);
            chk({nm, "_done_seen"}, {63'h0, got}, 64'h1);
            chk({nm, "_busy_cycles"}, 64'(bc), 64'd33);
        end
        chk({nm, "_hi"}, {32'h0, Hi_Out}, {32'h0, e.hi});
        chk({nm, "_lo"}, {32'h0, Lo_Out}, {32'h0, e.lo});
        if (e.iter) begin
            chk({nm, "_busy_after"}, {63'h0, Busy_Out}, 64'h0);
            @(posedge Clk_In); #1;
            chk({nm, "_done_width"}, {63'h0, Done_Out}, 64'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int bc;

        alu_tab[0]  = '{"add_wrap", 4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        alu_tab[1]  = '{"sub_wrap", 4'd1,  32'h00000000, 32'h00000001, 32'hFFFFFFFF};
        alu_tab[2]  = '{"and",      4'd2,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0};
        alu_tab[3]  = '{"or",       4'd3,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0};
        alu_tab[4]  = '{"xor",      4'd4,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00};
        alu_tab[5]  = '{"nor",      4'd5,  32'h00000000, 32'h00000000, 32'hFFFFFFFF};
        alu_tab[6]  = '{"lui",      4'd6,  32'hDEADBEEF, 32'h00001234, 32'h12340000};
        alu_tab[7]  = '{"slt",      4'd7,  32'hFFFFFFFF, 32'h00000001, 32'h00000001};
        alu_tab[8]  = '{"sltu",     4'd8,  32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        alu_tab[9]  = '{"sll",      4'd9,  32'h00000004, 32'h80000001, 32'h00000010};
        alu_tab[10] = '{"srl",      4'd10, 32'h00000004, 32'h80000000, 32'h08000000};
        alu_tab[11] = '{"sra",      4'd11, 32'h00000004, 32'h80000000, 32'hF8000000};
        alu_tab[12] = '{"sra_mask", 4'd11, 32'h00000024, 32'h80000000, 32'hF8000000};
        alu_tab[13] = '{"op12",     4'd12, 32'h12345678, 32'h9ABCDEF0, 32'h00000000};
        alu_tab[14] = '{"op15",     4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};

        Reset_N_In = 1'b0; Start_In = 1'b0; Md_Op_In = 3'd0;
        Alu_Op_In = 4'd0; SrcA_In = '0; SrcB_In = '0;
        #3;
        chk("rst_busy", {63'h0, Busy_Out}, 64'h0);
        chk("rst_done", {63'h0, Done_Out}, 64'h0);
        chk("rst_hi", {32'h0, Hi_Out}, 64'h0);
        chk("rst_lo", {32'h0, Lo_Out}, 64'h0);
        @(posedge Clk_In); #1;
        Reset_N_In = 1'b1;
        @(posedge Clk_In); #1;

        foreach (alu_tab[i]) begin
            Alu_Op_In = alu_tab[i].op; SrcA_In = alu_tab[i].a; SrcB_In = alu_tab[i].b;
            #1;
            chk({"alu_", alu_tab[i].nm}, {32'h0, Aluresult_Out}, {32'h0, alu_tab[i].y});
        end
        @(posedge Clk_In); #1;

        run_md("mthi",   3'd5, 32'hDEADBEEF, 32'h0);
        run_md("mtlo",   3'd6, 32'h12345678, 32'h0);
        run_md("nop0",   3'd0, 32'h11111111, 32'h22222222);
        run_md("nop7",   3'd7, 32'h33333333, 32'h44444444);
        run_md("multu",  3'd2, 32'hFFFFFFFF, 32'h00000002);
        run_md("mult",   3'd1, 32'hFFFFFFFD, 32'h00000005);
        run_md("div",    3'd3, 32'hFFFFFFF9, 32'h00000002);
        run_md("div_ov", 3'd3, 32'h80000000, 32'hFFFFFFFF);
        run_md("div_nd", 3'd3, 32'h00000064, 32'hFFFFFFF9);
        run_md("divu0",  3'd4, 32'h00000005, 32'h00000000);
        run_md("div0",   3'd3, 32'hFFFFFFF9, 32'h00000000);
        run_md("divu",   3'd4, 32'hFFFFFFFF, 32'h00000010);

        // Requests during busy are ignored and LO holds.
        Md_Op_In = 3'd4; SrcA_In = 32'd1000; SrcB_In = 32'd3; Start_In = 1'b1;
        @(posedge Clk_In); #1;
        Start_In = 1'b0;
        repeat (5) @(posedge Clk_In);
        #1;
        Md_Op_In = 3'd6; SrcA_In = 32'h0000AAAA; Start_In = 1'b1;
        @(posedge Clk_In); #1;
        chk("busy_mtlo_lo", {32'h0, Lo_Out}, {32'h0, model_lo});
        Md_Op_In = 3'd2; SrcA_In = 32'd9; SrcB_In = 32'd9;
        @(posedge Clk_In); #1;
        Start_In = 1'b0;
        chk("busy_hold_lo", {32'h0, Lo_Out}, {32'h0, model_lo});
        chk("busy_hold_hi", {32'h0, Hi_Out}, {32'h0, model_hi});
        wait_done(got, bc);
        chk("busy_ign_done", {63'h0, got}, 64'h1);
        chk("busy_ign_lo", {32'h0, Lo_Out}, 64'd333);
        chk("busy_ign_hi", {32'h0, Hi_Out}, 64'd1);
        @(posedge Clk_In); #1;
        chk("busy_ign_idle", {63'h0, Busy_Out}, 64'h0);

        // New operation accepted in the Done cycle.
        Md_Op_In = 3'd2; SrcA_In = 32'd3; SrcB_In = 32'd4; Start_In = 1'b1;
        @(posedge Clk_In); #1;
        Start_In = 1'b0;
        wait_done(got, bc);
        chk("b2b_first_done", {63'h0, got}, 64'h1);
        chk("b2b_first_lo", {32'h0, Lo_Out}, 64'd12);
        Md_Op_In = 3'd4; SrcA_In = 32'd100; SrcB_In = 32'd7; Start_In = 1'b1;
        @(posedge Clk_In); #1;
        Start_In = 1'b0; SrcA_In = 32'd0; SrcB_In = 32'd0;
        chk("b2b_accept", {63'h0, Busy_Out}, 64'h1);
        chk("b2b_hold_lo", {32'h0, Lo_Out}, 64'd12);
        wait_done(got, bc);
        chk("b2b_second_done", {63'h0, got}, 64'h1);
        chk("b2b_second_busy", 64'(bc), 64'd33);
        chk("b2b_second_lo", {32'h0, Lo_Out}, 64'd14);
        chk("b2b_second_hi", {32'h0, Hi_Out}, 64'd2);
        @(posedge Clk_In); #1;

        // Reset mid-DIVU aborts with no Done; first edge after release accepts.
        Md_Op_In = 3'd4; SrcA_In = 32'd500; SrcB_In = 32'd7; Start_In = 1'b1;
        @(posedge Clk_In); #1;
        Start_In = 1'b0;
        repeat (10) @(posedge Clk_In);
        #3;
        Reset_N_In = 1'b0;
        #1;
        chk("rst_mid_busy", {63'h0, Busy_Out}, 64'h0);
        chk("rst_mid_done", {63'h0, Done_Out}, 64'h0);
        chk("rst_mid_hi", {32'h0, Hi_Out}, 64'h0);
        chk("rst_mid_lo", {32'h0, Lo_Out}, 64'h0);
        model_hi = '0; model_lo = '0;
        @(posedge Clk_In); #1;
        chk("rst_hold_done", {63'h0, Done_Out}, 64'h0);
        Md_Op_In = 3'd2; SrcA_In = 32'd6; SrcB_In = 32'd7; Start_In = 1'b1;
        Reset_N_In = 1'b1;
        @(posedge Clk_In); #1;
        Start_In = 1'b0;
        chk("rst_first_accept", {63'h0, Busy_Out}, 64'h1);
        wait_done(got, bc);
        chk("rst_after_done", {63'h0, got}, 64'h1);
        chk("rst_after_busy", 64'(bc), 64'd33);
        chk("rst_after_lo", {32'h0, Lo_Out}, 64'd42);
        chk("rst_after_hi", {32'h0, Hi_Out}, 64'd0);
        @(posedge Clk_In); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
